uart_tx: RTL and testbench

8N1 UART transmitter that drives the SoC's `TXD` pin, currently tied low.
- It accepts one byte at a time over a valid/ready handshake from the core side.
- It serialises the byte LSB-first with one start bit and one stop bit at a fixed baud rate derived from the system clock.
- It runs in the divided `clk` domain of the SoC top level, alongside the LED counter.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_cnt.sv | 38 +++
 rtl/uart_tx.sv | 104 ++++++++++
 tb/tb_uart_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART types, constants and baud divisor helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Truncating divide; any remainder shows up as a small baud-rate error.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_cnt.sv
// ============================================================================
// Module   : uart_baud_cnt
// Brief    : Free-running bit-period counter with a tick on its last count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_count;
    logic               w_tick;

    assign w_tick = (r_count == c_last);
    assign o_tick = w_tick;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (w_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module   : uart_tx
// Brief    : 8N1 UART transmitter with valid/ready byte input, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 12_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int c_idx_w      = $clog2(UART_DATA_BITS);
    localparam logic [c_idx_w-1:0] c_last_bit = c_idx_w'(UART_DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_divisor
            $error("uart_tx: CLK_FREQ / BAUD must be at least 2");
        end
    endgenerate

    uart_state_t                r_state;
    logic [UART_DATA_BITS-1:0]  r_shift;
    logic [c_idx_w-1:0]         r_bit_idx;
    logic                       r_tx;
    logic                       w_tick;
    logic                       w_clr;

    // Holding the counter clear while idle means it starts at 0 on the first
    // START cycle, which gives the zero-latency start bit.
    assign w_clr = (r_state == IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_clr),
        .o_tick (w_tick)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_tx      <= UART_IDLE_LEVEL;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_shift <= i_data;
                        r_tx    <= ~UART_IDLE_LEVEL;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_tx      <= r_shift[0];
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == c_last_bit) begin
                            r_tx    <= UART_IDLE_LEVEL;
                            r_state <= STOP;
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= UART_IDLE_LEVEL;
                end
            endcase
        end
    end

    assign o_tx    = r_tx;
    assign o_ready = (r_state == IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Self-checking bench for uart_tx at CLKS_PER_BIT = 4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b1;
    logic       ready;
    logic       tx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb[$];
    logic       tx_s  [0:99];
    logic       rdy_s [0:99];

    uart_tx #(
        .CLK_FREQ (40),
        .BAUD     (10)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_data  (data),
        .i_valid (valid),
        .o_ready (ready),
        .o_tx    (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected line level at cycle c (1-based) of a frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int c);
        int j;
        j = (c - 1) / C;
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        return 1'b1;
    endfunction

    function automatic logic [7:0] decode(input int off);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = tx_s[off + C*(k+1) + 2];
        return b;
    endfunction

    // Drive one byte and record tx/ready for cycles 1..n after the accept edge.
    task automatic send_capture(input logic [7:0] b, input int n);
        data  = b;
        valid = 1'b1;
        step();
        valid = 1'b0;
        for (int c = 1; c <= n; c++) begin
            if (c > 1) step();
            tx_s[c]  = tx;
            rdy_s[c] = ready;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b1; data = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx[%0d]: got %b required 1", i, tx); end
            n_checks++;
            if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b required 1", i, ready); end
        end
        rst = 1'b0; valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (tx !== 1'b1) begin n_fail++; $display("FAIL post_reset_tx[%0d]: got %b required 1", i, tx); end
            n_checks++;
            if (ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready[%0d]: got %b required 1", i, ready); end
        end
    endtask

    task automatic test_single();
        logic [7:0] exp;
        sb.push_back(8'h55);
        send_capture(8'h55, 41);
        for (int c = 1; c <= 40; c++) begin
            n_checks++;
            if (tx_s[c] !== frame_bit(8'h55, c)) begin
                n_fail++; $display("FAIL single_tx[c%0d]: got %b required %b", c, tx_s[c], frame_bit(8'h55, c));
            end
            n_checks++;
            if (rdy_s[c] !== 1'b0) begin n_fail++; $display("FAIL single_ready_low[c%0d]: got %b required 0", c, rdy_s[c]); end
        end
        n_checks++;
        if (rdy_s[41] !== 1'b1) begin n_fail++; $display("FAIL single_ready_c41: got %b required 1", rdy_s[41]); end
        exp = sb.pop_front();
        n_checks++;
        if (decode(0) !== exp) begin n_fail++; $display("FAIL single_byte: got %h required %h", decode(0), exp); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        int fall;
        sb.push_back(8'hA5);
        sb.push_back(8'h3C);
        data  = 8'hA5;
        valid = 1'b1;
        step();
        data = 8'h3C;
        for (int c = 1; c <= 82; c++) begin
            if (c > 1) step();
            tx_s[c]  = tx;
            rdy_s[c] = ready;
            if (c == 42) valid = 1'b0;
        end
        for (int c = 1; c <= 81; c++) begin
            n_checks++;
            if (tx_s[c] !== (c <= 41 ? frame_bit(8'hA5, c) : frame_bit(8'h3C, c - 41))) begin
                n_fail++; $display("FAIL b2b_tx[c%0d]: got %b", c, tx_s[c]);
            end
        end
        fall = 0;
        for (int c = 37; c <= 82; c++) if (fall == 0 && tx_s[c] === 1'b0) fall = c;
        n_checks++;
        if (fall != 42) begin n_fail++; $display("FAIL b2b_second_start: got cycle %0d required 42", fall); end
        n_checks++;
        if (rdy_s[41] !== 1'b1 || rdy_s[42] !== 1'b0 || rdy_s[82] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready: got %b%b%b required 101", rdy_s[41], rdy_s[42], rdy_s[82]);
        end
        exp = sb.pop_front();
        n_checks++;
        if (decode(0) !== exp) begin n_fail++; $display("FAIL b2b_byte0: got %h required %h", decode(0), exp); end
        exp = sb.pop_front();
        n_checks++;
        if (decode(41) !== exp) begin n_fail++; $display("FAIL b2b_byte1: got %h required %h", decode(41), exp); end
    endtask

    task automatic test_busy_drop();
        logic [7:0] exp;
        int highs;
        sb.push_back(8'h0F);
        data  = 8'h0F;
        valid = 1'b1;
        step();
        valid = 1'b0;
        for (int c = 1; c <= 41; c++) begin
            if (c > 1) step();
            tx_s[c]  = tx;
            rdy_s[c] = ready;
            if (c == 15) begin data = 8'hFF; valid = 1'b1; end
            if (c == 16) valid = 1'b0;
        end
        highs = 0;
        for (int c = 1; c <= 40; c++) if (rdy_s[c] !== 1'b0) highs++;
        n_checks++;
        if (highs != 0) begin n_fail++; $display("FAIL busy_ready: got %0d high cycles required 0", highs); end
        for (int c = 1; c <= 40; c++) begin
            n_checks++;
            if (tx_s[c] !== frame_bit(8'h0F, c)) begin n_fail++; $display("FAIL busy_tx[c%0d]: got %b", c, tx_s[c]); end
        end
        exp = sb.pop_front();
        n_checks++;
        if (decode(0) !== exp) begin n_fail++; $display("FAIL busy_byte: got %h required %h", decode(0), exp); end
        highs = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (tx === 1'b1) highs++;
        end
        n_checks++;
        if (highs != 12) begin n_fail++; $display("FAIL busy_idle_after: got %0d high cycles required 12", highs); end
    endtask

    task automatic test_stability();
        logic [7:0] exp;
        sb.push_back(8'h81);
        data  = 8'h81;
        valid = 1'b1;
        step();
        valid = 1'b0;
        for (int c = 1; c <= 41; c++) begin
            if (c > 1) step();
            tx_s[c]  = tx;
            rdy_s[c] = ready;
            data = ~data;
        end
        for (int c = 1; c <= 40; c++) begin
            n_checks++;
            if (tx_s[c] !== frame_bit(8'h81, c)) begin n_fail++; $display("FAIL stable_tx[c%0d]: got %b", c, tx_s[c]); end
        end
        exp = sb.pop_front();
        n_checks++;
        if (decode(0) !== exp) begin n_fail++; $display("FAIL stable_byte: got %h required %h", decode(0), exp); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp;
        send_capture(8'h66, 18);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 19; c <= 23; c++) begin
            if (c > 19) step();
            n_checks++;
            if (tx !== 1'b1) begin n_fail++; $display("FAIL abort_tx[c%0d]: got %b required 1", c, tx); end
            n_checks++;
            if (ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready[c%0d]: got %b required 1", c, ready); end
        end
        sb.push_back(8'hC3);
        send_capture(8'hC3, 41);
        for (int c = 1; c <= 40; c++) begin
            n_checks++;
            if (tx_s[c] !== frame_bit(8'hC3, c)) begin n_fail++; $display("FAIL after_abort_tx[c%0d]: got %b", c, tx_s[c]); end
        end
        n_checks++;
        if (rdy_s[41] !== 1'b1) begin n_fail++; $display("FAIL after_abort_ready: got %b required 1", rdy_s[41]); end
        exp = sb.pop_front();
        n_checks++;
        if (decode(0) !== exp) begin n_fail++; $display("FAIL after_abort_byte: got %h required %h", decode(0), exp); end
    endtask

    initial begin
        test_reset();
        test_single();
        step();
        test_back_to_back();
        step();
        test_busy_drop();
        test_stability();
        step();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left required 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
